// File: rtl/leaf_pkg.sv
// Shared defaults and helpers for leaf page wrappers: payload/counter widths and
// the flat-bus channel slicing rule (channel i lives at [i*W +: W]).
package leaf_pkg;

  localparam int LEAF_PAYLOAD_BITS = 32;
  localparam int LEAF_CNT_BITS     = 16;

  // LSB of channel ch in a flat bus of w-bit channels
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/leaf_user_buffer_if.sv
// User-side stream bundle between leaf_interface and the user kernel, as seen
// by the elastic buffer (slave) and whoever drives it (master).
interface leaf_user_buffer_if import leaf_pkg::*; #(
  parameter int PAYLOAD_BITS  = LEAF_PAYLOAD_BITS,
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 2,
  parameter int CNT_BITS      = LEAF_CNT_BITS
);
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dn_in_data;
  logic [NUM_IN_PORTS-1:0]               dn_in_valid;
  logic [NUM_IN_PORTS-1:0]               dn_in_ready;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dn_out_data;
  logic [NUM_IN_PORTS-1:0]               dn_out_valid;
  logic [NUM_IN_PORTS-1:0]               dn_out_ready;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] up_in_data;
  logic [NUM_OUT_PORTS-1:0]              up_in_valid;
  logic [NUM_OUT_PORTS-1:0]              up_in_ready;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] up_out_data;
  logic [NUM_OUT_PORTS-1:0]              up_out_valid;
  logic [NUM_OUT_PORTS-1:0]              up_out_ready;
  logic [NUM_IN_PORTS*CNT_BITS-1:0]      dn_count;
  logic [NUM_OUT_PORTS*CNT_BITS-1:0]     up_count;

  modport slave (
    input  dn_in_data, dn_in_valid, dn_out_ready,
    input  up_in_data, up_in_valid, up_out_ready,
    output dn_in_ready, dn_out_data, dn_out_valid,
    output up_in_ready, up_out_data, up_out_valid,
    output dn_count, up_count
  );

  modport master (
    output dn_in_data, dn_in_valid, dn_out_ready,
    output up_in_data, up_in_valid, up_out_ready,
    input  dn_in_ready, dn_out_data, dn_out_valid,
    input  up_in_ready, up_out_data, up_out_valid,
    input  dn_count, up_count
  );
endinterface

// File: rtl/leaf_fifo_ch.sv
// One buffered channel: first-word-fall-through FIFO with registered input ready,
// synchronous flush and a saturating count of output-side transfers.
module leaf_fifo_ch #(
  parameter int W  = 32,
  parameter int DL = 2,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic [W-1:0]  i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [CW-1:0] o_count
);
  localparam int DEPTH = 1 << DL;
  localparam int PW    = (DL > 0) ? DL : 1;
  localparam logic [DL:0]   FULL = (DL+1)'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_wptr, r_rptr;
  logic [DL:0]   r_occ;
  logic          r_rdy;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_mem [DEPTH];

  logic          w_push, w_pop;
  logic [DL:0]   w_occ_nxt;

  // Ready is a flop (plus flush kill) so the kernel side never reaches the interface combinationally.
  assign o_ready = r_rdy & ~flush;
  assign o_valid = (r_occ != '0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_cnt;

  assign w_push = i_valid & o_ready;
  assign w_pop  = o_valid & i_ready & ~flush;

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_push && !w_pop)      w_occ_nxt = r_occ + 1'b1;
    else if (!w_push && w_pop) w_occ_nxt = r_occ - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_rdy  <= 1'b0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_rdy  <= 1'b1;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
      r_occ <= w_occ_nxt;
      // Full stays not-ready through a same-cycle pop; space shows up one cycle later.
      r_rdy <= (w_occ_nxt < FULL);
      if (w_pop && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/leaf_user_buffer.sv
// Elastic buffer between leaf_interface user ports and the user kernel: one
// independent FIFO channel per stream in each direction.
module leaf_user_buffer import leaf_pkg::*; #(
  parameter int PAYLOAD_BITS  = LEAF_PAYLOAD_BITS,
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 2,
  parameter int DEPTH_LOG2    = 2,
  parameter int CNT_BITS      = LEAF_CNT_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  leaf_user_buffer_if.slave bus
);
  logic [NUM_IN_PORTS-1:0][PAYLOAD_BITS-1:0]  w_dn_data;
  logic [NUM_IN_PORTS-1:0][CNT_BITS-1:0]      w_dn_cnt;
  logic [NUM_IN_PORTS-1:0]                    w_dn_rdy, w_dn_vld;
  logic [NUM_OUT_PORTS-1:0][PAYLOAD_BITS-1:0] w_up_data;
  logic [NUM_OUT_PORTS-1:0][CNT_BITS-1:0]     w_up_cnt;
  logic [NUM_OUT_PORTS-1:0]                   w_up_rdy, w_up_vld;

  assign bus.dn_in_ready  = w_dn_rdy;
  assign bus.dn_out_valid = w_dn_vld;
  assign bus.dn_out_data  = w_dn_data;
  assign bus.dn_count     = w_dn_cnt;
  assign bus.up_in_ready  = w_up_rdy;
  assign bus.up_out_valid = w_up_vld;
  assign bus.up_out_data  = w_up_data;
  assign bus.up_count     = w_up_cnt;

  for (genvar g = 0; g < NUM_IN_PORTS; g++) begin : g_dn
    leaf_fifo_ch #(.W(PAYLOAD_BITS), .DL(DEPTH_LOG2), .CW(CNT_BITS)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .i_data  (bus.dn_in_data[ch_lsb(g, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .i_valid (bus.dn_in_valid[g]),
      .o_ready (w_dn_rdy[g]),
      .o_data  (w_dn_data[g]),
      .o_valid (w_dn_vld[g]),
      .i_ready (bus.dn_out_ready[g]),
      .o_count (w_dn_cnt[g])
    );
  end

  for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_up
    leaf_fifo_ch #(.W(PAYLOAD_BITS), .DL(DEPTH_LOG2), .CW(CNT_BITS)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .i_data  (bus.up_in_data[ch_lsb(g, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .i_valid (bus.up_in_valid[g]),
      .o_ready (w_up_rdy[g]),
      .o_data  (w_up_data[g]),
      .o_valid (w_up_vld[g]),
      .i_ready (bus.up_out_ready[g]),
      .o_count (w_up_cnt[g])
    );
  end

endmodule

// File: tb/tb_leaf_user_buffer.sv
// Bench for leaf_user_buffer: queue-based reference model for the main instance,
// a vector table for back-pressure, and a small-counter instance for saturation.
module tb_leaf_user_buffer;
  localparam int PB = 32, NI = 1, NO = 2, DL = 2, CB = 16, SCB = 4;
  localparam int DEPTH = 4, NCH = NI + NO;
  localparam longint CMAX = (64'd1 << CB) - 1;

  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic rst_s_n = 1'b0, flush_s = 1'b0;
  always #5 clk = ~clk;

  leaf_user_buffer_if #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .CNT_BITS(CB)) b();
  leaf_user_buffer #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
                     .DEPTH_LOG2(DL), .CNT_BITS(CB)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b));

  leaf_user_buffer_if #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .CNT_BITS(SCB)) s();
  leaf_user_buffer #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
                     .DEPTH_LOG2(DL), .CNT_BITS(SCB)) dut_sat (
    .clk(clk), .reset_n(rst_s_n), .flush(flush_s), .bus(s));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // channel c: 0..NI-1 downstream, NI.. upstream
  function automatic logic in_v(input int c);
    if (c < NI) return b.dn_in_valid[c];
    return b.up_in_valid[c-NI];
  endfunction
  function automatic logic [PB-1:0] in_d(input int c);
    if (c < NI) return b.dn_in_data[c*PB +: PB];
    return b.up_in_data[(c-NI)*PB +: PB];
  endfunction
  function automatic logic out_r(input int c);
    if (c < NI) return b.dn_out_ready[c];
    return b.up_out_ready[c-NI];
  endfunction
  function automatic logic dut_rdy(input int c);
    if (c < NI) return b.dn_in_ready[c];
    return b.up_in_ready[c-NI];
  endfunction
  function automatic logic dut_vld(input int c);
    if (c < NI) return b.dn_out_valid[c];
    return b.up_out_valid[c-NI];
  endfunction
  function automatic logic [PB-1:0] dut_dat(input int c);
    if (c < NI) return b.dn_out_data[c*PB +: PB];
    return b.up_out_data[(c-NI)*PB +: PB];
  endfunction
  function automatic logic [CB-1:0] dut_cnt(input int c);
    if (c < NI) return b.dn_count[c*CB +: CB];
    return b.up_count[(c-NI)*CB +: CB];
  endfunction

  // Reference model: a queue per channel, readiness = room left after the last edge.
  logic [PB-1:0] mq [NCH][$];
  bit            m_rdy [NCH];
  longint        m_cnt [NCH];

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!reset_n) begin
        mq[c].delete();
        m_rdy[c] <= 1'b0;
        m_cnt[c] <= 0;
      end else if (flush) begin
        mq[c].delete();
        m_rdy[c] <= 1'b1;
      end else begin
        if (mq[c].size() != 0 && out_r(c)) begin
          void'(mq[c].pop_front());
          if (m_cnt[c] < CMAX) m_cnt[c] <= m_cnt[c] + 1;
        end
        if (in_v(c) && m_rdy[c]) mq[c].push_back(in_d(c));
        m_rdy[c] <= (mq[c].size() < DEPTH);
      end
    end
  end

  task automatic chk_model();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("m_rdy%0d", c), 64'(dut_rdy(c)), 64'(m_rdy[c] & ~flush));
      chk($sformatf("m_vld%0d", c), 64'(dut_vld(c)), 64'(mq[c].size() != 0));
      if (mq[c].size() != 0) chk($sformatf("m_dat%0d", c), 64'(dut_dat(c)), 64'(mq[c][0]));
      chk($sformatf("m_cnt%0d", c), 64'(dut_cnt(c)), 64'(m_cnt[c]));
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic look(); #1; chk_model(); endtask

  task automatic idle();
    b.dn_in_valid = '0; b.dn_in_data = '0; b.dn_out_ready = '0;
    b.up_in_valid = '0; b.up_in_data = '0; b.up_out_ready = '0;
    flush = 1'b0;
  endtask
  task automatic idle_s();
    s.dn_in_valid = '0; s.dn_in_data = '0; s.dn_out_ready = '0;
    s.up_in_valid = '0; s.up_in_data = '0; s.up_out_ready = '0;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_dat;
  } vec_t;
  vec_t tv[12];

  int first, nseen, nbad;

  initial begin
    // back-pressure sequence on dn ch0, depth 4
    tv[0]  = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA0};
    tv[2]  = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 32'hA0};
    tv[3]  = '{1'b1, 32'hA3, 1'b0, 1'b1, 1'b1, 32'hA0};
    tv[4]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 32'hA0};
    tv[5]  = '{1'b1, 32'hA4, 1'b1, 1'b0, 1'b1, 32'hA0};
    tv[6]  = '{1'b1, 32'hA4, 1'b0, 1'b1, 1'b1, 32'hA1};
    tv[7]  = '{1'b1, 32'hA5, 1'b1, 1'b0, 1'b1, 32'hA1};
    tv[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2};
    tv[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA3};
    tv[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA4};
    tv[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0};

    idle(); idle_s();

    // reset held with upstream valid high
    b.up_in_valid = '1;
    for (int i = 0; i < 5; i++) begin
      tick(); look();
      chk("rst_vld", 64'({b.dn_out_valid, b.up_out_valid}), 64'd0);
      chk("rst_rdy", 64'({b.dn_in_ready, b.up_in_ready}), 64'd0);
      chk("rst_cnt", 64'({b.dn_count, b.up_count}), 64'd0);
    end
    tick(); b.up_in_valid = '0; reset_n = 1'b1; look();
    chk("rel_rdy_pre", 64'({b.dn_in_ready, b.up_in_ready}), 64'd0);
    tick(); look();
    chk("rel_rdy_post", 64'({b.dn_in_ready, b.up_in_ready}), 64'b111);

    // streaming 1..32
    first = -1; nseen = 0; nbad = 0;
    for (int k = 0; k < 34; k++) begin
      tick();
      b.dn_out_ready = 1'b1;
      b.dn_in_valid = (k < 32) ? 1'b1 : 1'b0;
      b.dn_in_data = 32'(k + 1);
      look();
      if (b.dn_out_valid[0]) begin
        if (first < 0) first = k;
        if (b.dn_out_data[31:0] != 32'(k)) nbad++;
        nseen++;
      end
    end
    chk("str_first", 64'(first), 64'd1);
    chk("str_words", 64'(nseen), 64'd32);
    chk("str_order", 64'(nbad), 64'd0);
    tick(); idle(); look();
    chk("str_cnt", 64'(b.dn_count), 64'd32);

    // full / back-pressure table
    for (int r = 0; r < 12; r++) begin
      tick();
      b.dn_in_valid = tv[r].iv; b.dn_in_data = tv[r].id; b.dn_out_ready = tv[r].ordy;
      look();
      chk($sformatf("bp_rdy[%0d]", r), 64'(b.dn_in_ready), 64'(tv[r].e_rdy));
      chk($sformatf("bp_vld[%0d]", r), 64'(b.dn_out_valid), 64'(tv[r].e_vld));
      if (tv[r].e_vld) chk($sformatf("bp_dat[%0d]", r), 64'(b.dn_out_data), 64'(tv[r].e_dat));
    end

    // channel independence: up ch1 stalled, ch0 free
    for (int k = 0; k < 8; k++) begin
      tick();
      b.up_out_ready = 2'b01; b.up_in_valid = 2'b11;
      b.up_in_data = {32'(32'h100 + k), 32'(k)};
      b.dn_in_valid = '0; b.dn_out_ready = '0;
      look();
    end
    tick(); b.up_in_valid = '0; look();
    chk("ind_cnt0", 64'(b.up_count[15:0]), 64'd7);
    chk("ind_cnt1", 64'(b.up_count[31:16]), 64'd0);
    chk("ind_rdy1", 64'(b.up_in_ready[1]), 64'd0);
    chk("ind_vld1", 64'(b.up_out_valid[1]), 64'd1);
    for (int k = 0; k < 6; k++) begin
      tick(); b.up_out_ready = 2'b11; look();
    end

    // flush with 3 words per FIFO, push and pop asserted
    for (int k = 0; k < 3; k++) begin
      tick(); idle();
      b.dn_in_valid = '1; b.up_in_valid = '1;
      b.dn_in_data = 32'(32'hF0 + k); b.up_in_data = {32'(32'hE0 + k), 32'(32'hD0 + k)};
      look();
    end
    tick();
    b.dn_out_ready = '1; b.up_out_ready = '1; flush = 1'b1;
    look();
    chk("fl_rdy0", 64'({b.dn_in_ready, b.up_in_ready}), 64'd0);
    chk("fl_vld_during", 64'({b.dn_out_valid, b.up_out_valid}), 64'b111);
    tick(); idle(); look();
    chk("fl_vld_after", 64'({b.dn_out_valid, b.up_out_valid}), 64'd0);
    chk("fl_rdy_after", 64'({b.dn_in_ready, b.up_in_ready}), 64'b111);
    chk("fl_dn_cnt", 64'(b.dn_count), 64'(m_cnt[0]));
    chk("fl_up_cnt", 64'(b.up_count), {32'd0, 16'(m_cnt[2]), 16'(m_cnt[1])});

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      tick();
      b.dn_in_valid = NI'($urandom); b.up_in_valid = NO'($urandom);
      b.dn_out_ready = NI'($urandom); b.up_out_ready = NO'($urandom);
      b.dn_in_data = $urandom; b.up_in_data = {$urandom, $urandom};
      flush = ($urandom_range(0, 31) == 0);
      look();
    end
    tick(); idle(); look();

    // saturation on the 4-bit counter instance
    tick(); rst_s_n = 1'b1;
    tick(); s.dn_out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(); s.dn_in_valid = 1'b1; s.dn_in_data = 32'(k);
    end
    tick(); s.dn_in_valid = 1'b0;
    tick(); tick(); #1;
    chk("sat_cnt", 64'(s.dn_count), 64'd15);

    // async reset in the middle of a burst
    s.dn_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); s.dn_in_valid = 1'b1; s.dn_in_data = 32'(32'h50 + k);
      s.up_in_valid = 2'b11;
    end
    tick(); #2;
    chk("sat_pre_vld", 64'({s.dn_out_valid, s.up_out_valid}), 64'b111);
    rst_s_n = 1'b0; #1;
    chk("arst_vld", 64'({s.dn_out_valid, s.up_out_valid}), 64'd0);
    chk("arst_rdy", 64'({s.dn_in_ready, s.up_in_ready}), 64'd0);
    chk("arst_cnt", 64'({s.dn_count, s.up_count}), 64'd0);
    idle_s();
    tick(); rst_s_n = 1'b1;
    tick(); #1;
    chk("arst_rel_rdy", 64'({s.dn_in_ready, s.up_in_ready}), 64'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
